// File: rtl/load_extend_pipe.sv
// Load-data lane extractor and extender for the MEM->WB path.
// One registered result slot behind a valid/ready handshake with flush.
module load_extend_pipe #(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [2:0]        in_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_err
);

    localparam bit IS64 = (DATA_W == 64);

    localparam logic [2:0] LD_WU   = 3'b101;
    localparam logic [2:0] LD_D    = 3'b110;
    localparam logic [2:0] LD_RSVD = 3'b111;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_ILL = 2'b10;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_err_q, out_err_d;

    logic              is_b, is_h, is_w, is_d, is_rsvd, is_uns;
    logic              illegal, misal, accept;
    logic [DATA_W-1:0] b_sh, h_sh, w_sh;
    logic [DATA_W-1:0] res_data;
    logic [1:0]        res_err;

    // Keep the low w bits of v; fill the rest with the given bit.
    function automatic logic [DATA_W-1:0] extend(
        input logic [DATA_W-1:0] v,
        input int                w,
        input logic              fill
    );
        logic [DATA_W-1:0] m;
        m      = ~({DATA_W{1'b1}} << w);
        extend = v & m;
        if (fill) begin
            extend = extend | ~m;
        end
    endfunction

    assign is_uns  = in_type[0];
    assign is_b    = (in_type[2:1] == 2'b00);
    assign is_h    = (in_type[2:1] == 2'b01);
    assign is_w    = (in_type[2:1] == 2'b10);
    assign is_d    = (in_type == LD_D);
    assign is_rsvd = (in_type == LD_RSVD);

    assign illegal = is_rsvd || (!IS64 && (in_type == LD_WU || is_d));

    assign misal = (is_h && in_off[0])
                || (is_w && (in_off[1:0] != 2'b00))
                || (is_d && (in_off != '0));

    assign b_sh = in_data >> {in_off, 3'b000};
    assign h_sh = in_data >> {in_off[OFF_W-1:1], 4'b0000};
    assign w_sh = in_data >> {in_off >> 2, 5'b00000};

    always_comb begin
        res_data = '0;
        res_err  = ERR_OK;
        if (illegal) begin
            res_err = ERR_ILL;
        end else if (misal) begin
            res_err = ERR_MIS;
        end else begin
            unique case (1'b1)
                is_b:    res_data = extend(b_sh, 8, b_sh[7] & ~is_uns);
                is_h:    res_data = extend(h_sh, 16, h_sh[15] & ~is_uns);
                is_w:    res_data = extend(w_sh, 32, w_sh[31] & ~is_uns);
                is_d:    res_data = in_data;
                default: res_data = '0;
            endcase
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Flush wins over both a new request and a consume.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = res_data;
            out_err_d   = res_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= ERR_OK;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_load_extend_pipe.sv
// Scoreboard bench for load_extend_pipe: 32- and 64-bit instances
// share one handshake stream and are checked against a reference model.
module tb_load_extend_pipe;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_type = 3'b000;
    logic [2:0]  in_off = 3'b000;
    logic [63:0] in_data = 64'h0;

    logic        r32, v32, r64, v64;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [1:0]  e32, e64;

    typedef struct {
        logic [63:0] d32;
        logic [1:0]  e32;
        logic [63:0] d64;
        logic [1:0]  e64;
    } exp_t;

    exp_t sb[$];
    bit   model_busy = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_pop = 0;

    always #5 clk = ~clk;

    load_extend_pipe #(.DATA_W(32)) u32 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(r32),
        .in_data(in_data[31:0]), .in_off(in_off[1:0]), .in_type(in_type),
        .out_valid(v32), .out_ready(out_ready),
        .out_data(d32), .out_err(e32)
    );

    load_extend_pipe #(.DATA_W(64)) u64 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(r64),
        .in_data(in_data), .in_off(in_off), .in_type(in_type),
        .out_valid(v64), .out_ready(out_ready),
        .out_data(d64), .out_err(e64)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: lane of nb bytes at byte offset off, little-endian.
    function automatic void ref_load(input int dw, input logic [2:0] t,
                                     input logic [63:0] d, input int off,
                                     output logic [63:0] r,
                                     output logic [1:0] e);
        int nb;
        logic [63:0] m, v;
        nb = 1 << t[2:1];
        r = 64'h0;
        if (t == 3'd7 || (dw == 32 && (t == 3'd5 || t == 3'd6))) begin
            e = 2'd2;
            return;
        end
        if (off % nb != 0) begin
            e = 2'd1;
            return;
        end
        e = 2'd0;
        v = d >> (off * 8);
        m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (nb * 8)) - 64'h1);
        v = v & m;
        if (!t[0] && nb * 8 < dw && v[nb*8-1]) v = v | ~m;
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        r = v;
    endfunction

    // Monitor: compares held output with the oldest expected entry.
    always @(negedge clk) begin
        if (!resetn) begin
            model_busy = 1'b0;
        end else begin
            model_busy = (sb.size() != 0);
            chk("out_valid32", {63'h0, v32}, {63'h0, model_busy});
            chk("out_valid64", {63'h0, v64}, {63'h0, model_busy});
            if (model_busy) begin
                chk("out_data32", {32'h0, d32}, sb[0].d32);
                chk("out_err32", {62'h0, e32}, {62'h0, sb[0].e32});
                chk("out_data64", d64, sb[0].d64);
                chk("out_err64", {62'h0, e64}, {62'h0, sb[0].e64});
                if (out_ready || flush) begin
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] t,
                         input logic [2:0] off, input logic [63:0] d,
                         input logic fl, input logic rdy);
        exp_t x;
        logic er;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_type   = t;
        in_off    = off;
        in_data   = d;
        flush     = fl;
        out_ready = rdy;
        @(negedge clk);
        #1;
        er = !model_busy || rdy;
        chk("in_ready32", {63'h0, r32}, {63'h0, er});
        chk("in_ready64", {63'h0, r64}, {63'h0, er});
        if (v && er && !fl) begin
            ref_load(32, t, {32'h0, d[31:0]}, int'(off[1:0]), x.d32, x.e32);
            ref_load(64, t, d, int'(off), x.d64, x.e64);
            sb.push_back(x);
        end
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 3'b000, 3'b000, 64'h0, 1'b0, rdy);
    endtask

    initial begin
        int n0;
        logic [2:0] t, off;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid32", {63'h0, v32}, 64'h0);
        chk("rst_data32", {32'h0, d32}, 64'h0);
        chk("rst_err64", {62'h0, e64}, 64'h0);
        resetn = 1'b1;
        idle(1'b1);

        drive(1'b1, 3'b000, 3'd1, 64'h0000_0000_12F4_80A5, 1'b0, 1'b0);
        idle(1'b0);
        chk("lb_sext32", {32'h0, d32}, 64'h0000_0000_FFFF_FF80);
        chk("lb_sext64", d64, 64'hFFFF_FFFF_FFFF_FF80);
        drive(1'b1, 3'b001, 3'd1, 64'h0000_0000_12F4_80A5, 1'b0, 1'b1);
        idle(1'b0);
        chk("lbu_zext32", {32'h0, d32}, 64'h0000_0000_0000_0080);

        drive(1'b1, 3'b010, 3'd2, 64'h0000_0000_8001_7FFF, 1'b0, 1'b1);
        idle(1'b0);
        chk("lh_off2", {32'h0, d32}, 64'h0000_0000_FFFF_8001);
        drive(1'b1, 3'b010, 3'd1, 64'h0000_0000_8001_7FFF, 1'b0, 1'b1);
        idle(1'b0);
        chk("lh_mis_err", {62'h0, e32}, 64'h1);
        chk("lh_mis_data", {32'h0, d32}, 64'h0);
        drive(1'b1, 3'b101, 3'd0, 64'h0000_0000_8001_7FFF, 1'b0, 1'b1);
        idle(1'b0);
        chk("lwu32_ill", {62'h0, e32}, 64'h2);
        chk("lwu64_ok", d64, 64'h0000_0000_8001_7FFF);

        drive(1'b1, 3'b100, 3'd4, 64'h9000_0001_0000_0002, 1'b0, 1'b1);
        idle(1'b0);
        chk("lw64_hi", d64, 64'hFFFF_FFFF_9000_0001);
        drive(1'b1, 3'b101, 3'd4, 64'h9000_0001_0000_0002, 1'b0, 1'b1);
        idle(1'b0);
        chk("lwu64_hi", d64, 64'h0000_0000_9000_0001);
        drive(1'b1, 3'b110, 3'd0, 64'h9000_0001_0000_0002, 1'b0, 1'b1);
        idle(1'b0);
        chk("ld64", d64, 64'h9000_0001_0000_0002);
        chk("ld32_ill", {62'h0, e32}, 64'h2);

        drive(1'b1, 3'b000, 3'd3, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 3'b011, 3'd2, 64'hABCD_0000_1234_5678, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 3'd5, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1);
        idle(1'b0);
        chk("bp_valid", {63'h0, v64}, 64'h1);

        drive(1'b1, 3'b000, 3'd0, 64'h55, 1'b1, 1'b1);
        idle(1'b1);
        chk("flush_drop", {63'h0, v32}, 64'h0);

        n0 = n_pop;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  {$urandom, $urandom}, 1'b0, 1'b1);
        end
        idle(1'b1);
        chk("stream4", 64'(n_pop - n0), 64'd4);

        drive(1'b1, 3'b101, 3'd0, 64'h0000_0000_0000_00A5, 1'b0, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        chk("arst_valid32", {63'h0, v32}, 64'h0);
        chk("arst_err32", {62'h0, e32}, 64'h0);
        chk("arst_valid64", {63'h0, v64}, 64'h0);
        chk("arst_data64", d64, 64'h0);
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        idle(1'b1);

        for (int i = 0; i < 400; i++) begin
            t   = 3'($urandom_range(0, 7));
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) off = off & ~3'((1 << t[2:1]) - 1);
            drive($urandom_range(0, 3) != 0, t, off, {$urandom, $urandom},
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end
        repeat (3) idle(1'b1);
        chk("drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
